instr_fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of the decode/control unit. Generates sequential PCs, issues requests to instruction memory over a request/grant and response-valid handshake, and buffers returned words in a small in-order queue. Presents instruction, its PC and the 5-bit opcode field `inst[6:2]` to decode over a valid/ready handshake. Accepts branch/JALR redirects, flushing buffered words and discarding in-flight responses from the old path.

---
 rtl/instr_fetch_queue_if.sv | 28 ++
 rtl/instr_fetch_queue.sv | 126 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: groups the fetch stage's memory and decode handshakes.
// master: the fetch stage. It drives imem_req/imem_addr and id_valid/id_inst/id_pc/id_opcode.
//         It receives imem_gnt/imem_rvalid/imem_rdata, redirect/redirect_pc and id_ready.
// slave:  the surrounding memory, control and decode logic (the mirror of master).
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [4:0]  id_opcode;

    modport master (
        output imem_req, imem_addr, id_valid, id_inst, id_pc, id_opcode,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_opcode,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential PC generation, credit-limited instruction memory requests,
// an in-order DEPTH-entry response queue feeding decode, and redirect flush with stale-response drop.
// Ports: clk, rst_n (asynchronous, active-low).
//        bus (master modport) carries three groups of signals:
//          - memory: imem_req, imem_addr, imem_gnt, imem_rvalid, imem_rdata
//          - redirect: redirect, redirect_pc
//          - decode: id_valid, id_ready, id_inst, id_pc, id_opcode
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, resp_pc_q;
    logic [CW-1:0] outst_q, discard_q, count_q;
    logic [PW-1:0] head_q, tail_q;
    entry_t        mem_q [DEPTH];
    entry_t        hold_q;
    entry_t        head_c;

    logic          req_c, grant_c, rsp_c, push_c, pop_c;
    logic [CW:0]   credit_c;
    logic [31:0]   target_c;
    logic          unused_ok;

    // Bits [1:0] of the redirect target are forced to zero.
    assign unused_ok = ^bus.redirect_pc[1:0];
    assign target_c  = {bus.redirect_pc[31:2], 2'b00};

    // Handshake qualification. A response with nothing outstanding is a protocol error and is ignored.
    always_comb begin
        credit_c = (CW+1)'(outst_q) + (CW+1)'(count_q);
        req_c    = (state_q == RUN) && !bus.redirect && (credit_c < (CW+1)'(DEPTH));
        grant_c  = req_c && bus.imem_gnt;
        rsp_c    = bus.imem_rvalid && (outst_q != '0);
        push_c   = rsp_c && (discard_q == '0) && !bus.redirect;
        pop_c    = (count_q != '0) && bus.id_ready;
    end

    // Boot lasts one cycle so the first request follows a full cycle out of reset.
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end
    end

    // Control state. A redirect overrides every other update in its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            hold_q    <= '{inst: NOP, pc: RESET_PC};
        end else begin
            state_q <= state_d;
            if (bus.redirect) begin
                // Every request still in flight belongs to the old path.
                pc_q      <= target_c;
                resp_pc_q <= target_c;
                outst_q   <= outst_q - CW'(rsp_c);
                discard_q <= outst_q - CW'(rsp_c);
                count_q   <= '0;
                head_q    <= '0;
                tail_q    <= '0;
            end else begin
                if (grant_c) begin
                    pc_q <= pc_q + 32'd4;
                end
                outst_q <= outst_q + CW'(grant_c) - CW'(rsp_c);
                if (rsp_c && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
                if (push_c) begin
                    tail_q    <= tail_q + PW'(1);
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (pop_c) begin
                    head_q <= head_q + PW'(1);
                end
                count_q <= count_q + CW'(push_c) - CW'(pop_c);
            end
            // Remember the presented head so decode outputs hold once the queue empties.
            if (count_q != '0) begin
                hold_q <= mem_q[head_q];
            end
        end
    end

    // Queue storage; occupancy tracking makes a reset unnecessary here.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[tail_q] <= '{inst: bus.imem_rdata, pc: resp_pc_q};
        end
    end

    always_comb begin
        head_c = (count_q != '0) ? mem_q[head_q] : hold_q;
    end

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = (count_q != '0);
    assign bus.id_inst   = head_c.inst;
    assign bus.id_pc     = head_c.pc;
    assign bus.id_opcode = head_c.inst[6:2];
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized bench with a memory model and an expected-PC scoreboard.
// Each kept response's PC is queued; a separate monitor compares the decode head against it.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] INST_OFS = 32'h0000_0100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];

    int          total, bad, cyc, epoch;
    int          p_gnt, p_ready, p_redir, p_spur, lat_min, lat_max;
    bit          run_m, mon_en, force_redir;
    logic [31:0] force_pc, exp_fetch_pc, last_inst, last_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic idle_inputs();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready    = 1'b0;
    endtask

    // Holds reset for two cycles, checks reset outputs, releases at a falling edge.
    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        idle_inputs();
        pend.delete();
        sb.delete();
        epoch++;
        exp_fetch_pc = RESET_PC;
        run_m        = 1'b0;
        force_redir  = 1'b0;
        last_inst    = NOP;
        last_pc      = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        check("rst_imem_req",  32'(bus.imem_req), 32'd0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);
        check("rst_id_valid",  32'(bus.id_valid), 32'd0);
        check("rst_id_inst",   bus.id_inst, NOP);
        check("rst_id_pc",     bus.id_pc, RESET_PC);
        check("rst_id_opcode", 32'(bus.id_opcode), 32'd4);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // One cycle: drive at the falling edge, check requests at +1, update the model at +3.
    task automatic step();
        bit    rsp_real;
        bit    exp_req;
        pend_t r;
        bus.imem_gnt = roll(p_gnt);
        bus.id_ready = roll(p_ready);
        rsp_real = 1'b0;
        if (pend.size() > 0) begin
            rsp_real = (pend[0].ready <= cyc);
        end
        if (rsp_real) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend[0].addr + INST_OFS;
        end else begin
            bus.imem_rvalid = (pend.size() == 0) && roll(p_spur);
            bus.imem_rdata  = $urandom;
        end
        if (force_redir) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = force_pc;
            force_redir     = 1'b0;
        end else begin
            bus.redirect    = roll(p_redir);
            bus.redirect_pc = $urandom;
        end
        #1;
        exp_req = run_m && !bus.redirect && ((pend.size() + sb.size()) < int'(DEPTH));
        check("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (bus.imem_req && exp_req) begin
            check("imem_addr", bus.imem_addr, exp_fetch_pc);
        end
        if (bus.imem_req && bus.imem_gnt) begin
            pend.push_back('{addr: exp_fetch_pc, epoch: epoch,
                             ready: cyc + int'($urandom_range(lat_max, lat_min))});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        #2;
        if (rsp_real) begin
            r = pend.pop_front();
            if ((r.epoch == epoch) && !bus.redirect) begin
                sb.push_back(r.addr);
            end
        end
        if (bus.redirect) begin
            sb.delete();
            epoch++;
            exp_fetch_pc = bus.redirect_pc & ~32'h3;
        end
        run_m = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    // Decode-side monitor: the head must match the oldest expected PC, or hold when empty.
    initial begin
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("id_valid", 32'(bus.id_valid), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    e_pc   = sb[0];
                    e_inst = e_pc + INST_OFS;
                    check("id_pc", bus.id_pc, e_pc);
                    check("id_inst", bus.id_inst, e_inst);
                    check("id_opcode", 32'(bus.id_opcode), 32'(e_inst[6:2]));
                    last_pc   = e_pc;
                    last_inst = e_inst;
                    if (bus.id_valid && bus.id_ready) begin
                        sb.delete(0);
                    end
                end else begin
                    check("hold_id_pc", bus.id_pc, last_pc);
                    check("hold_id_inst", bus.id_inst, last_inst);
                    check("hold_id_opcode", 32'(bus.id_opcode), 32'(last_inst[6:2]));
                end
            end
        end
    end

    initial begin
        bit hit;
        total = 0; bad = 0; cyc = 0; epoch = 0;
        p_gnt = 100; p_ready = 100; p_redir = 0; p_spur = 0;
        lat_min = 1; lat_max = 1;
        force_pc = '0;
        do_reset();

        // Streaming with single-cycle memory.
        repeat (20) step();

        // Decode back-pressure: requests stop once credits are used, then drain in order.
        p_ready = 0;
        repeat (8) step();
        p_ready = 100;
        repeat (8) step();

        // Three-cycle memory; redirect while two requests are outstanding.
        lat_min = 3; lat_max = 3;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (pend.size() == 2) begin
                force_redir = 1'b1;
                force_pc    = 32'h0000_0200;
                hit         = 1'b1;
            end
            step();
        end
        check("wait_two_outstanding", 32'(hit), 32'd1);
        repeat (16) step();

        // Redirect coinciding with a response and a pop, unaligned target.
        lat_min = 1; lat_max = 1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (sb.size() > 0 && pend.size() > 0 && pend[0].ready <= cyc) begin
                force_redir = 1'b1;
                force_pc    = 32'h0000_0302;
                hit         = 1'b1;
            end
            step();
        end
        check("wait_redirect_rsp_pop", 32'(hit), 32'd1);
        repeat (12) step();

        // Grant stall of four cycles with a redirect in the middle.
        p_gnt = 0;
        repeat (2) step();
        force_redir = 1'b1;
        force_pc    = 32'h0000_0400;
        repeat (2) step();
        p_gnt = 100;
        repeat (12) step();

        // Address wrap at the top of memory.
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFF8;
        repeat (14) step();

        // Randomized traffic.
        for (int blk = 0; blk < 15; blk++) begin
            p_gnt   = int'($urandom_range(100, 30));
            p_ready = int'($urandom_range(100, 20));
            p_redir = int'($urandom_range(8, 0));
            p_spur  = 10;
            lat_min = 1;
            lat_max = int'($urandom_range(4, 1));
            repeat (100) step();
        end

        // Asynchronous reset between clock edges.
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_imem_req",  32'(bus.imem_req), 32'd0);
        check("async_imem_addr", bus.imem_addr, RESET_PC);
        check("async_id_valid",  32'(bus.id_valid), 32'd0);
        check("async_id_inst",   bus.id_inst, NOP);
        check("async_id_pc",     bus.id_pc, RESET_PC);
        check("async_id_opcode", 32'(bus.id_opcode), 32'd4);
        do_reset();
        p_gnt = 100; p_ready = 100; p_redir = 0; p_spur = 0;
        lat_min = 1; lat_max = 2;
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
